// File: rtl/seq_detect_pkg.sv
// Shared types for the "1011" detector scheduler: detector state encodings,
// scheduler FSM states and the detector next-state function.
package seq_detect_pkg;

  typedef enum logic [2:0] {
    S0    = 3'b000,
    S1    = 3'b001,
    S10   = 3'b011,
    S101  = 3'b010,
    S1011 = 3'b110
  } det_state_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DRAIN,
    DONE
  } sched_state_t;

  // Overlapping Moore transitions; inputs not listed keep the current state.
  function automatic det_state_t det_next(input det_state_t s, input logic b);
    det_state_t n;
    n = s;
    case (s)
      S0:      if (b) n = S1;
      S1:      if (!b) n = S10;
      S10:     n = b ? S101 : S0;
      S101:    n = b ? S1011 : S10;
      S1011:   n = b ? S1 : S10;
      default: n = S0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/seq1011_moore_clr.sv
// Serial "1011" Moore detector: one bit per enabled cycle; det_out is high in S1011.
// clr wins over en and returns the detector to S0 on the next edge.
module seq1011_moore_clr
  import seq_detect_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic det_out
);

  det_state_t state_q;
  det_state_t state_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = S0;
    end else if (en) begin
      state_d = det_next(state_q, din);
    end
  end

  assign det_out = (state_q == S1011);

endmodule

// File: rtl/seq_detect_scheduler.sv
// Round-robin shares one serial "1011" detector among NUM_REQ word requesters.
// req in arbitrating cycle T -> gnt at T+1 -> done at T+DATA_W+2; requesters hold req until gnt.
module seq_detect_scheduler
  import seq_detect_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      busy,
  output logic                      done,
  output logic [ID_W-1:0]           done_id,
  output logic [CNT_W-1:0]          match_cnt
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [BW-1:0]    LAST_BIT = BW'(DATA_W - 1);

  sched_state_t       state_q;
  sched_state_t       state_d;
  logic [DATA_W-1:0]  shreg;
  logic [BW-1:0]      bit_idx;
  logic [CNT_W-1:0]   cnt;
  logic [ID_W-1:0]    job_id;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    win;
  logic               found;
  logic               arbitrate;
  logic               capture;
  logic               det_out;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // First requester at or above rr_ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[wrap_add(rr_ptr, i)]) begin
        found = 1'b1;
        win   = wrap_add(rr_ptr, i);
      end
    end
  end

  assign arbitrate = (state_q == IDLE) || (state_q == DONE);
  assign capture   = arbitrate && found;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = found ? SHIFT : IDLE;
      SHIFT:      if (bit_idx == LAST_BIT) state_d = DRAIN;
      DRAIN:      state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      bit_idx <= '0;
      cnt     <= '0;
      job_id  <= '0;
      rr_ptr  <= '0;
      gnt     <= '0;
    end else if (capture) begin
      shreg   <= data[int'(win)*DATA_W +: DATA_W];
      bit_idx <= '0;
      cnt     <= '0;
      job_id  <= win;
      rr_ptr  <= wrap_add(win, 1);
      gnt     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
    end else begin
      gnt <= '0;
      if (state_q == SHIFT) begin
        shreg   <= {shreg[DATA_W-2:0], 1'b0};
        bit_idx <= bit_idx + 1'b1;
      end
      // det_out lags the fed bit by one edge, so DRAIN picks up the final bit.
      if ((state_q == SHIFT || state_q == DRAIN) && det_out && cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  seq1011_moore_clr u_det (
    .clock   (clock),
    .reset   (reset),
    .clr     (capture),
    .en      (state_q == SHIFT),
    .din     (shreg[DATA_W-1]),
    .det_out (det_out)
  );

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign done_id   = job_id;
  assign match_cnt = cnt;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed and randomized bench for seq_detect_scheduler with a job-level reference model.
module tb_seq_detect_scheduler;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int IW = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  data;
  logic [NR-1:0]     gnt;
  logic              busy;
  logic              done;
  logic [IW-1:0]     done_id;
  logic [CW-1:0]     match_cnt;

  logic [1:0]        req2;
  logic [63:0]       data2;
  logic [1:0]        gnt2;
  logic              busy2;
  logic              done2;
  logic [0:0]        done_id2;
  logic [2:0]        match_cnt2;

  seq_detect_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .CNT_W(CW), .ID_W(IW)) dut (
    .clock(clock), .reset(reset), .req(req), .data(data), .gnt(gnt),
    .busy(busy), .done(done), .done_id(done_id), .match_cnt(match_cnt)
  );

  seq_detect_scheduler #(.NUM_REQ(2), .DATA_W(32), .CNT_W(3), .ID_W(1)) dut_wide (
    .clock(clock), .reset(reset), .req(req2), .data(data2), .gnt(gnt2),
    .busy(busy2), .done(done2), .done_id(done_id2), .match_cnt(match_cnt2)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Number of "1011" substrings in the MSB-first bit string, saturated to the counter width.
  function automatic int ref_count(input logic [63:0] w, input int width, input int cw);
    int n;
    n = 0;
    for (int i = width - 1; i >= 3; i--)
      if (w[i -: 4] == 4'b1011) n++;
    if (n > (1 << cw) - 1) n = (1 << cw) - 1;
    return n;
  endfunction

  // Job-level model: age counts cycles since the capture edge.
  bit m_active = 0;
  int m_age = 0;
  int m_id = 0;
  int m_cnt = 0;
  int m_rr = 0;

  always @(negedge clock) begin
    if (reset) begin
      m_active = 0;
      m_rr = 0;
      check("reset_outputs", {gnt, busy, done, done_id, match_cnt}, 0);
    end else begin
      check("gnt", gnt, (m_active && m_age == 1) ? (1 << m_id) : 0);
      check("busy", busy, m_active);
      check("done", done, m_active && m_age == DW + 2);
      if (m_active && m_age == DW + 2) begin
        check("done_id", done_id, m_id);
        check("match_cnt", match_cnt, m_cnt);
      end
      if (!m_active || m_age == DW + 2) begin
        m_active = 0;
        for (int k = 0; k < NR; k++) begin
          if (!m_active && req[(m_rr + k) % NR]) begin
            m_active = 1;
            m_age = 1;
            m_id = (m_rr + k) % NR;
            m_cnt = ref_count(64'(data[m_id*DW +: DW]), DW, CW);
            m_rr = (m_id + 1) % NR;
          end
        end
      end else begin
        m_age++;
      end
    end
  end

  task automatic wait_done(input int t0, output int lat);
    lat = -1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clock);
      if (done) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  task automatic single(input string nm, input int id, input logic [DW-1:0] w, input int exp_cnt);
    int t0;
    int lat;
    @(posedge clock); #1;
    t0 = cyc;
    data[id*DW +: DW] = w;
    req = NR'(1 << id);
    @(negedge clock);
    @(negedge clock);
    check({nm, "_gnt"}, gnt, 1 << id);
    @(posedge clock); #1;
    req = '0;
    wait_done(t0, lat);
    check({nm, "_latency"}, lat, 10);
    check({nm, "_id"}, done_id, id);
    check({nm, "_cnt"}, match_cnt, exp_cnt);
  endtask

  task automatic pulse_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    int t0;
    int t1;
    int lat;
    int prev;
    int ndone;
    int order[5];
    logic [7:0] w;
    order = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    req = '0;
    data = '0;
    req2 = '0;
    data2 = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Tests 1-2: overlap, match on the last bit, no match.
    single("t1", 0, 8'b1011_0110, 2);
    single("t2a", 0, 8'h0B, 1);
    single("t2b", 0, 8'hFF, 0);

    // Test 3: all four requesting continuously -> rotating grants 10 cycles apart.
    pulse_reset();
    @(posedge clock); #1;
    for (int i = 0; i < NR; i++) data[i*DW +: DW] = 8'($urandom);
    req = 4'b1111;
    prev = 0;
    for (int g = 0; g < 5; g++) begin
      lat = -1;
      for (int n = 0; n < 20; n++) begin
        @(negedge clock);
        if (gnt != 0) begin
          lat = n;
          break;
        end
      end
      check("t3_gnt_order", gnt, 1 << order[g]);
      if (g > 0) check("t3_gnt_spacing", cyc - prev, 10);
      prev = cyc;
      @(posedge clock); #1;
      data[order[g]*DW +: DW] = 8'($urandom);
    end
    req = '0;
    repeat (12) @(posedge clock);

    // Test 4: back-to-back jobs; the second must not inherit state from the first.
    @(posedge clock); #1;
    t0 = cyc;
    data[2*DW +: DW] = 8'hB6;
    data[3*DW +: DW] = 8'h00;
    req = 4'b1100;
    @(negedge clock);
    @(negedge clock);
    check("t4_gnt_a", gnt, 4'b0100);
    @(posedge clock); #1;
    req[2] = 1'b0;
    wait_done(t0, lat);
    check("t4_lat_a", lat, 10);
    check("t4_id_a", done_id, 2);
    check("t4_cnt_a", match_cnt, 2);
    t1 = cyc;
    @(negedge clock);
    check("t4_gnt_b", gnt, 4'b1000);
    @(posedge clock); #1;
    req = '0;
    wait_done(t1, lat);
    check("t4_gap_b", lat, 10);
    check("t4_id_b", done_id, 3);
    check("t4_cnt_b", match_cnt, 0);

    // Test 5: reset in the 4th SHIFT cycle abandons the job.
    @(posedge clock); #1;
    data[0 +: DW] = 8'hB6;
    req = 4'b0001;
    @(posedge clock); #1;
    req = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("t5_reset_busy", busy, 0);
    check("t5_reset_done", done, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(negedge clock);
      if (done) ndone++;
    end
    check("t5_no_done", ndone, 0);
    w = 8'($urandom);
    single("t5_next", 1, w, ref_count(64'(w), DW, CW));

    // Test 6: 32-bit word with a 3-bit counter saturates 8 matches at 7.
    @(posedge clock); #1;
    t0 = cyc;
    data2[31:0] = 32'hBBBB_BBBB;
    req2 = 2'b01;
    @(negedge clock);
    @(negedge clock);
    check("t6_gnt", gnt2, 2'b01);
    @(posedge clock); #1;
    req2 = '0;
    lat = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clock);
      if (done2) begin
        lat = cyc - t0;
        break;
      end
    end
    check("t6_latency", lat, 34);
    check("t6_id", done_id2, 0);
    check("t6_cnt_sat", match_cnt2, 7);

    // Randomized traffic with occasional resets; the model process does the checking.
    for (int c = 0; c < 2500; c++) begin
      @(posedge clock); #1;
      for (int i = 0; i < NR; i++) begin
        if (req[i] && gnt[i]) req[i] = 1'b0;
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          data[i*DW +: DW] = ($urandom_range(0, 3) == 0) ? 8'hBB : 8'($urandom);
          req[i] = 1'b1;
        end
      end
      reset = ($urandom_range(0, 299) == 0);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    req = '0;
    repeat (15) @(posedge clock);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    checks++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("%0d/%0d checks passed", passed, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
